// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks one active-low row per tick, debounces whole
// 16-key frames and reports a single accepted key as a hex code plus a valid strobe.
module keypad_scanner #(
  parameter int DIVIDE_BY       = 17,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  // nibble i holds the hex value of the key at row i/4, column i%4
  localparam logic [63:0] KEYMAP = 64'hDEF0_C987_B654_A321;
  localparam logic [3:0]  DB_MAX = 4'(DEBOUNCE_FRAMES);

  typedef enum logic {IDLE, PRESSED} state_t;

  logic [3:0]           col_meta, col_sync;
  logic [DIVIDE_BY-1:0] tick_cnt;
  logic                 tick, frame_end;
  logic [1:0]           r_idx;
  logic [11:0]          snap;
  logic [15:0]          prev, frame;
  logic [3:0]           stable_cnt, cnt_next, hot_idx;
  logic                 debounced, one_hot;
  state_t               state;

  assign tick      = &tick_cnt;
  assign frame_end = tick && (r_idx == 2'd3);

  // row 3 is folded in live on the frame-end tick, so snap only keeps rows 0..2
  always_comb begin
    frame   = {~col_sync, snap};
    hot_idx = '0;
    for (int i = 0; i < 16; i++)
      if (frame[i]) hot_idx = 4'(i);
    one_hot = (frame != 16'd0) && ((frame & (frame - 16'd1)) == 16'd0);
    if (frame != prev)           cnt_next = '0;
    else if (stable_cnt == DB_MAX) cnt_next = stable_cnt;
    else                         cnt_next = stable_cnt + 4'd1;
    debounced = (cnt_next == DB_MAX);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      col_meta   <= 4'hF;
      col_sync   <= 4'hF;
      tick_cnt   <= '0;
      r_idx      <= 2'd0;
      row        <= 4'b1110;
      snap       <= '0;
      prev       <= '0;
      stable_cnt <= '0;
    end else begin
      col_meta <= col;
      col_sync <= col_meta;
      tick_cnt <= tick_cnt + 1'b1;
      if (tick) begin
        case (r_idx)
          2'd0:    snap[3:0]  <= ~col_sync;
          2'd1:    snap[7:4]  <= ~col_sync;
          2'd2:    snap[11:8] <= ~col_sync;
          default: begin
            prev       <= frame;
            stable_cnt <= cnt_next;
          end
        endcase
        r_idx <= r_idx + 2'd1;
        row   <= ~(4'b0001 << (r_idx + 2'd1));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      key_code  <= 4'h0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (frame_end && debounced) begin
        case (state)
          IDLE: if (one_hot) begin
            key_code  <= KEYMAP[{hot_idx, 2'b00} +: 4];
            key_valid <= 1'b1;
            key_held  <= 1'b1;
            state     <= PRESSED;
          end
          default: if (frame == 16'd0) begin
            key_held <= 1'b0;
            state    <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad pulls columns low for
// pressed keys on the active row; outputs are sampled on the falling clock edge.
module tb_keypad_scanner;

  localparam int FRAME = 64;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] col, row, key_code;
  logic       key_valid, key_held;
  logic [15:0] keys = '0;
  int          errors = 0, checks = 0, pulses = 0, p0;

  keypad_scanner #(.DIVIDE_BY(4), .DEBOUNCE_FRAMES(2)) dut (
    .clk(clk), .reset_n(reset_n), .col(col), .row(row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
  );

  always #5 clk = ~clk;

  always_comb begin
    col = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[4*r+c] && !row[r]) col[c] = 1'b0;
  end

  // counts every cycle key_valid is high, so a stretched strobe shows up as extra pulses
  always @(posedge clk) if (key_valid === 1'b1) pulses++;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // bit index of key (r,c) in the keys mask
  function automatic int kb(input int r, input int c);
    return 4*r + c;
  endfunction

  initial begin
    logic [3:0] exp_rows [3];
    int n;
    exp_rows[0] = 4'b1101; exp_rows[1] = 4'b1011; exp_rows[2] = 4'b0111;

    repeat (3) @(negedge clk);
    check("rst_row", row, 4'b1110);
    check("rst_code", key_code, 4'h0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held", key_held, 1'b0);
    reset_n = 1'b1;

    // row walk: each value dwells exactly one tick period
    n = 0;
    while (row == 4'b1110 && n < 40) begin @(negedge clk); n++; end
    check("first_dwell", 16'(n), 16'd16);
    for (int j = 0; j < 3; j++) begin
      check("row_seq", row, exp_rows[j]);
      n = 0;
      while (row == exp_rows[j] && n < 40) begin @(negedge clk); n++; end
      check("row_dwell", 16'(n), 16'd16);
    end
    check("row_wrap", row, 4'b1110);

    // key 6 held stable
    p0 = pulses;
    keys[kb(1,2)] = 1'b1;
    frames(4); repeat (8) @(negedge clk);
    check("k6_latency", 16'(pulses - p0), 16'd1);
    frames(2);
    check("k6_pulses", 16'(pulses - p0), 16'd1);
    check("k6_code", key_code, 4'h6);
    check("k6_held", key_held, 1'b1);
    keys = '0;
    frames(4); repeat (8) @(negedge clk);
    check("k6_release", key_held, 1'b0);
    check("k6_no_repeat", 16'(pulses - p0), 16'd1);
    check("k6_code_hold", key_code, 4'h6);

    // key F chattering one frame in two, then stable
    p0 = pulses;
    for (int i = 0; i < 4; i++) begin
      keys[kb(3,1)] = 1'b1; frames(1);
      keys[kb(3,1)] = 1'b0; frames(1);
    end
    check("chatter_none", 16'(pulses - p0), 16'd0);
    check("chatter_held", key_held, 1'b0);
    keys[kb(3,1)] = 1'b1;
    frames(6);
    check("kF_pulses", 16'(pulses - p0), 16'd1);
    check("kF_code", key_code, 4'hF);
    keys = '0; frames(5);
    check("kF_release", key_held, 1'b0);

    // two keys together are ignored until one is let go
    p0 = pulses;
    keys[kb(0,0)] = 1'b1; keys[kb(2,2)] = 1'b1;
    frames(6);
    check("multi_none", 16'(pulses - p0), 16'd0);
    check("multi_held", key_held, 1'b0);
    check("multi_code", key_code, 4'hF);
    keys[kb(2,2)] = 1'b0;
    frames(6);
    check("k1_pulses", 16'(pulses - p0), 16'd1);
    check("k1_code", key_code, 4'h1);
    keys = '0; frames(5);

    // slide A -> D without release, then a fresh D
    p0 = pulses;
    keys[kb(0,3)] = 1'b1;
    frames(6);
    check("kA_pulses", 16'(pulses - p0), 16'd1);
    check("kA_code", key_code, 4'hA);
    keys = '0; keys[kb(3,3)] = 1'b1;
    frames(6);
    check("slide_pulses", 16'(pulses - p0), 16'd1);
    check("slide_code", key_code, 4'hA);
    check("slide_held", key_held, 1'b1);
    keys = '0; frames(5);
    check("slide_release", key_held, 1'b0);
    keys[kb(3,3)] = 1'b1;
    frames(6);
    check("kD_pulses", 16'(pulses - p0), 16'd2);
    check("kD_code", key_code, 4'hD);
    keys = '0; frames(5);

    // reset while 5 is mid-debounce
    p0 = pulses;
    keys[kb(1,1)] = 1'b1;
    frames(2);
    check("k5_pre_rst", 16'(pulses - p0), 16'd0);
    reset_n = 1'b0;
    #1;
    check("mid_rst_code", key_code, 4'h0);
    check("mid_rst_held", key_held, 1'b0);
    check("mid_rst_row", row, 4'b1110);
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    frames(6);
    check("k5_pulses", 16'(pulses - p0), 16'd1);
    check("k5_code", key_code, 4'h5);
    check("k5_held", key_held, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
Input-side counterpart to the seven-segment output path: scans a 4x4 matrix keypad (Pmod KYPD) by driving one row low at a time and reading the four column inputs. Synchronizes and debounces the columns, then reports single keypresses as a hex code with a one-cycle valid strobe. Sits in the top level beside the display path; its key_code can feed the decoder in place of, or alongside, the switches.

Parameters:
DIVIDE_BY, 17, scan tick period is 2**DIVIDE_BY clk cycles; the bench sets a small value.
DEBOUNCE_FRAMES, 3, number of additional identical full-keypad frames required before a change is accepted (1..15).

Ports:
clk  input  1  board clock, 100 MHz
reset_n  input  1  asynchronous active-low reset
col  input  4  keypad columns, active-low, pulled up externally; asynchronous to clk
row  output  4  keypad rows, active-low, exactly one bit low at all times
key_code  output  4  hex value of the last accepted key
key_valid  output  1  one-cycle pulse when a new key is accepted
key_held  output  1  high while the accepted key remains debounced-pressed

Behaviour:
- Reset (async assert, sync release): row=4'b1110, key_code=0, key_valid=0, key_held=0. Tick counter, row index, stable count, frame snapshot and previous snapshot are all cleared; the cleared snapshot value means "all released". Reset mid-scan aborts the frame; no key_valid is generated.
- col passes through a 2-flop synchronizer, then inverts to pressed-high.
- Tick: a DIVIDE_BY-bit free-running counter. tick=1 on the cycle the counter equals all-ones, so the period is 2**DIVIDE_BY cycles.
- On tick, sync'd columns for the current row index r are written to snapshot bits [4r+3:4r], then r increments mod 4 and row becomes ~(1<<r_new). The row therefore dwells a full tick period before it is sampled.
- Frame end: the tick at r=3. On that tick the complete 16-bit frame (row 3 bits included) is compared with the previous frame:
  - differs: stable_cnt=0.
  - equal: stable_cnt increments, saturating at DEBOUNCE_FRAMES.
  - previous frame is then updated to the current frame.
- Debounced frame is valid when stable_cnt==DEBOUNCE_FRAMES, i.e. DEBOUNCE_FRAMES+1 consecutive identical frames.
- Key map, row r / column c (col[c]):
  - r0: 1 2 3 A
  - r1: 4 5 6 B
  - r2: 7 8 9 C
  - r3: 0 F E D
- FSM, evaluated on the frame-end tick only:
  - IDLE: debounced frame has exactly one bit set -> key_code=mapped value, key_valid=1 on the following cycle for one cycle, key_held=1, go to PRESSED. Zero keys, or two or more keys, -> stay in IDLE with no output change.
  - PRESSED: debounced frame all-zero -> key_held=0, go to IDLE. Any other debounced frame (same key, a different key, multi-key) -> stay; no new key_valid and key_code unchanged. A release is required between accepted keys.
  - A non-debounced frame (stable_cnt below threshold) never changes state.
- key_code holds its value after release, until the next accepted key.
- Press latency: key_valid occurs at most (DEBOUNCE_FRAMES+2) frames plus 3 cycles after a stable press begins.
- Chatter shorter than a frame resets stable_cnt. A press lasting fewer than DEBOUNCE_FRAMES+1 frames is never reported.

Test Plan:
- DIVIDE_BY=4 (tick every 16 cycles, frame=64 cycles), DEBOUNCE_FRAMES=2, bench keypad model: col[c]=0 when row[r]=0 and key(r,c) is pressed.
- Reset -> row=1110, key_code=0, key_valid=0, key_held=0. row then cycles 1110,1101,1011,0111 with each value lasting 16 cycles.
- Hold key "6" (r1,c2) stable -> exactly one key_valid pulse within 4 frames, with key_code=6 and key_held=1. Release -> key_held falls within 4 frames; no second pulse.
- Hold "F" (r3,c1) while toggling col for 1 frame out of every 2 -> no key_valid. Then hold stable -> single pulse with key_code=F.
- Hold "1" and "9" together from IDLE -> no key_valid. Release "9" while keeping "1" -> pulse with key_code=1.
- Press "A" until accepted, then slide to "D" without a release -> no new pulse and key_code stays A. Release all, then press "D" -> pulse with key_code=D.
- Assert reset_n=0 while "5" is held mid-debounce -> outputs clear immediately. After release of reset with "5" still held -> one pulse with key_code=5 after full debounce.
